// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: decodes load/store ops, runs a single outstanding
// request on the data-memory port and formats load data for writeback.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_wa,
  input  logic        ex_wreg,
  input  logic        ex_whilo,
  input  logic [31:0] ex_dreg,
  input  logic [63:0] ex_dhilo,
  output logic [4:0]  mem_wa,
  output logic        mem_wreg,
  output logic        mem_whilo,
  output logic        mem_mreg,
  output logic [31:0] mem_dreg,
  output logic [63:0] mem_dhilo,
  output logic [3:0]  mem_dre,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_mem,
  output logic        mem_ade,
  output logic        mem_berr,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LBU = 4'b0010;
  localparam logic [3:0] OP_LH  = 4'b0011;
  localparam logic [3:0] OP_LHU = 4'b0100;
  localparam logic [3:0] OP_LW  = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b0110;
  localparam logic [3:0] OP_SH  = 4'b0111;
  localparam logic [3:0] OP_SW  = 4'b1000;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_berr;
  logic          r_dm_req;
  logic          r_dm_we;
  logic [3:0]    r_dm_be;
  logic [31:0]   r_dm_addr;
  logic [31:0]   r_dm_wdata;
  logic [3:0]    r_op;
  logic [1:0]    r_off;

  logic          w_is_byte;
  logic          w_is_half;
  logic          w_is_word;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_is_mem;
  logic          w_misalign;
  logic          w_start;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_lbyte;
  logic [15:0]   w_lhalf;
  logic          w_r_is_load;
  logic [31:0]   w_load;

  // Opcode decode; unlisted codes fall through as NOP.
  always_comb begin
    w_is_byte  = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    case (ex_op)
      OP_LB, OP_LBU: begin w_is_byte = 1'b1; w_is_load  = 1'b1; end
      OP_LH, OP_LHU: begin w_is_half = 1'b1; w_is_load  = 1'b1; end
      OP_LW:         begin w_is_word = 1'b1; w_is_load  = 1'b1; end
      OP_SB:         begin w_is_byte = 1'b1; w_is_store = 1'b1; end
      OP_SH:         begin w_is_half = 1'b1; w_is_store = 1'b1; end
      OP_SW:         begin w_is_word = 1'b1; w_is_store = 1'b1; end
      default:       ;
    endcase
  end

  assign w_is_mem   = w_is_load | w_is_store;
  assign w_misalign = (w_is_half & ex_addr[0]) | (w_is_word & (ex_addr[1:0] != 2'b00));
  assign w_start    = (r_state == S_IDLE) & w_is_mem & ~w_misalign;

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0000_0000;
    if (w_is_byte) begin
      case (ex_addr[1:0])
        2'b00:   w_be = 4'b1000;
        2'b01:   w_be = 4'b0100;
        2'b10:   w_be = 4'b0010;
        default: w_be = 4'b0001;
      endcase
    end else if (w_is_half) begin
      w_be = ex_addr[1] ? 4'b0011 : 4'b1100;
    end else if (w_is_word) begin
      w_be = 4'b1111;
    end
    if (w_is_store) begin
      if (w_is_byte) begin
        w_wdata = {4{ex_wdata[7:0]}};
      end else if (w_is_half) begin
        w_wdata = {2{ex_wdata[15:0]}};
      end else begin
        w_wdata = ex_wdata;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rdata    <= 32'h0000_0000;
      r_berr     <= 1'b0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_be    <= 4'b0000;
      r_dm_addr  <= 32'h0000_0000;
      r_dm_wdata <= 32'h0000_0000;
      r_op       <= OP_NOP;
      r_off      <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            r_berr     <= 1'b0;
            r_dm_req   <= 1'b1;
            r_dm_we    <= w_is_store;
            r_dm_be    <= w_be;
            r_dm_addr  <= {ex_addr[31:2], 2'b00};
            r_dm_wdata <= w_wdata;
            r_op       <= ex_op;
            r_off      <= ex_addr[1:0];
          end
        end
        S_WAIT: begin
          // An ack in the final counted cycle still wins over the timeout.
          if (dm_ack) begin
            r_rdata  <= dm_rdata;
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_berr   <= 1'b1;
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_dm_req <= 1'b0;
          r_dm_we  <= 1'b0;
        end
      endcase
    end
  end

  // Lane extraction for the completed load.
  always_comb begin
    case (r_off)
      2'b00:   w_lbyte = r_rdata[31:24];
      2'b01:   w_lbyte = r_rdata[23:16];
      2'b10:   w_lbyte = r_rdata[15:8];
      default: w_lbyte = r_rdata[7:0];
    endcase
    w_lhalf     = r_off[1] ? r_rdata[15:0] : r_rdata[31:16];
    w_r_is_load = 1'b0;
    w_load      = 32'h0000_0000;
    case (r_op)
      OP_LB:   begin w_r_is_load = 1'b1; w_load = {{24{w_lbyte[7]}}, w_lbyte}; end
      OP_LBU:  begin w_r_is_load = 1'b1; w_load = {24'h000000, w_lbyte}; end
      OP_LH:   begin w_r_is_load = 1'b1; w_load = {{16{w_lhalf[15]}}, w_lhalf}; end
      OP_LHU:  begin w_r_is_load = 1'b1; w_load = {16'h0000, w_lhalf}; end
      OP_LW:   begin w_r_is_load = 1'b1; w_load = r_rdata; end
      default: ;
    endcase
  end

  // MEM/WB side. Any stalled cycle is a bubble, so write enables drop with stall.
  always_comb begin
    mem_wa    = ex_wa;
    mem_wreg  = ex_wreg;
    mem_whilo = ex_whilo;
    mem_mreg  = 1'b0;
    mem_dreg  = ex_dreg;
    mem_dhilo = ex_dhilo;
    mem_dre   = 4'b0000;
    stall_mem = 1'b0;
    mem_ade   = 1'b0;
    mem_berr  = 1'b0;
    if (cpu_rst) begin
      mem_wreg  = 1'b0;
      mem_whilo = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem) begin
            mem_wreg  = 1'b0;
            mem_whilo = 1'b0;
            if (w_misalign) begin
              mem_ade = 1'b1;
            end else begin
              stall_mem = 1'b1;
            end
          end
        end
        S_WAIT: begin
          stall_mem = 1'b1;
          mem_wreg  = 1'b0;
          mem_whilo = 1'b0;
        end
        S_DONE: begin
          if (r_berr) begin
            mem_berr  = 1'b1;
            mem_wreg  = 1'b0;
            mem_whilo = 1'b0;
          end else if (w_r_is_load) begin
            mem_mreg = 1'b1;
            mem_dre  = r_dm_be;
            mem_dreg = w_load;
          end
        end
        default: begin
          mem_wreg  = 1'b0;
          mem_whilo = 1'b0;
        end
      endcase
    end
  end

  // Handshake: dm_req stays high from the cycle after issue until the edge that
  // samples dm_ack=1 (or the timeout); addr/be/we/wdata are stable while it is high.
  assign dm_req      = r_dm_req & ~cpu_rst;
  assign dm_we       = r_dm_we & ~cpu_rst;
  assign dm_addr     = r_dm_addr;
  assign dm_be       = r_dm_be;
  assign dm_wdata    = r_dm_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of single-cycle IDLE cases, directed multi-cycle
// sequences and randomized ops checked against an arithmetic model of the stage.
module tb_mem_access_stage;

  localparam int TO = 4;
  localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4,
                         LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_wa;
  logic        ex_wreg;
  logic        ex_whilo;
  logic [31:0] ex_dreg;
  logic [63:0] ex_dhilo;
  logic [4:0]  mem_wa;
  logic        mem_wreg;
  logic        mem_whilo;
  logic        mem_mreg;
  logic [31:0] mem_dreg;
  logic [63:0] mem_dhilo;
  logic [3:0]  mem_dre;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall_mem;
  logic        mem_ade;
  logic        mem_berr;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
    .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_wa(ex_wa), .ex_wreg(ex_wreg), .ex_whilo(ex_whilo),
    .ex_dreg(ex_dreg), .ex_dhilo(ex_dhilo),
    .mem_wa(mem_wa), .mem_wreg(mem_wreg), .mem_whilo(mem_whilo), .mem_mreg(mem_mreg),
    .mem_dreg(mem_dreg), .mem_dhilo(mem_dhilo), .mem_dre(mem_dre),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_mem(stall_mem), .mem_ade(mem_ade), .mem_berr(mem_berr),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial cpu_clk_50M = 1'b0;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic        e_ade;
    logic        e_wb;
  } vec_t;
  vec_t tbl[10];

  // Reference model: sizes and lane positions computed arithmetically.
  function automatic int m_size(input logic [3:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit m_is_load(input logic [3:0] op);
    return (op >= LB) && (op <= LW);
  endfunction

  function automatic bit m_mis(input logic [3:0] op, input logic [31:0] addr);
    int s = m_size(op);
    int off = int'(addr[1:0]);
    return (s != 0) && ((off % s) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
    int s = m_size(op);
    int off = int'(addr[1:0]);
    logic [7:0] t;
    t = 8'((1 << s) - 1) << (4 - s - off);
    return t[3:0];
  endfunction

  function automatic logic [31:0] m_store_data(input logic [3:0] op, input logic [31:0] w);
    case (m_size(op))
      1:       return w[7:0] * 32'h0101_0101;
      2:       return w[15:0] * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int s = m_size(op);
    int off = int'(addr[1:0]);
    longint v;
    longint lim;
    lim = longint'(1) << (8 * s);
    v = longint'(rdata >> (8 * (4 - s - off))) & (lim - 1);
    if ((op == LB || op == LH) && v >= (lim >> 1)) v = v - lim;
    return v[31:0];
  endfunction

  // Scoreboard helper
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Driver tasks; every task starts and ends 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    ex_op    = op;
    ex_addr  = addr;
    ex_wdata = wd;
    ex_wa    = 5'($urandom);
    ex_wreg  = 1'b1;
    ex_whilo = 1'b1;
    ex_dreg  = $urandom;
    ex_dhilo = {$urandom, $urandom};
  endtask

  // One IDLE cycle that must not start a request (NOP, invalid or misaligned op).
  task automatic one_cycle(input string tag, input logic e_ade, input logic e_wb);
    dm_ack   = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    #4;
    chk({tag, "_ade"},   mem_ade,   e_ade);
    chk({tag, "_wreg"},  mem_wreg,  e_wb ? ex_wreg : 1'b0);
    chk({tag, "_whilo"}, mem_whilo, e_wb ? ex_whilo : 1'b0);
    chk({tag, "_stall"}, stall_mem, 1'b0);
    chk({tag, "_req"},   dm_req,    1'b0);
    chk({tag, "_mreg"},  mem_mreg,  1'b0);
    chk({tag, "_dre"},   mem_dre,   4'b0000);
    chk({tag, "_berr"},  mem_berr,  1'b0);
    chk({tag, "_dreg"},  mem_dreg,  ex_dreg);
    chk({tag, "_wa"},    mem_wa,    ex_wa);
    chk({tag, "_dhilo"}, mem_dhilo, ex_dhilo);
    next_cycle();
  endtask

  // Full aligned memory op using the current ex_* inputs. ack_at is the WAIT cycle
  // index (0-based) where dm_ack is raised; <0 or >=TO means no ack in time.
  task automatic mem_op(input int ack_at, input logic [31:0] rdata, output int stall_cycles);
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
    bit          e_berr;
    int          waits;
    e_be   = m_be(ex_op, ex_addr);
    e_wd   = m_store_data(ex_op, ex_wdata);
    e_ld   = m_load(ex_op, ex_addr, rdata);
    e_berr = (ack_at < 0) || (ack_at >= TO);
    waits  = e_berr ? TO : ack_at + 1;
    stall_cycles = 0;
    dm_ack   = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    #4;
    chk("issue_stall", stall_mem, 1'b1);
    chk("issue_req",   dm_req,    1'b0);
    chk("issue_wreg",  mem_wreg,  1'b0);
    chk("issue_ade",   mem_ade,   1'b0);
    if (stall_mem === 1'b1) stall_cycles++;
    next_cycle();
    for (int k = 0; k < waits; k++) begin
      dm_ack   = (k == ack_at);
      dm_rdata = (k == ack_at) ? rdata : $urandom;
      #4;
      chk("wait_req",   dm_req,    1'b1);
      chk("wait_addr",  dm_addr,   {ex_addr[31:2], 2'b00});
      chk("wait_be",    dm_be,     e_be);
      chk("wait_we",    dm_we,     !m_is_load(ex_op));
      if (!m_is_load(ex_op)) chk("wait_wdata", dm_wdata, e_wd);
      chk("wait_stall", stall_mem, 1'b1);
      chk("wait_wreg",  mem_wreg,  1'b0);
      chk("wait_whilo", mem_whilo, 1'b0);
      chk("wait_berr",  mem_berr,  1'b0);
      if (stall_mem === 1'b1) stall_cycles++;
      next_cycle();
    end
    dm_ack   = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    #4;
    chk("done_stall", stall_mem, 1'b0);
    chk("done_req",   dm_req,    1'b0);
    chk("done_berr",  mem_berr,  e_berr);
    chk("done_ade",   mem_ade,   1'b0);
    chk("done_wa",    mem_wa,    ex_wa);
    if (e_berr) begin
      chk("done_berr_wreg", mem_wreg, 1'b0);
      chk("done_berr_mreg", mem_mreg, 1'b0);
    end else if (m_is_load(ex_op)) begin
      chk("done_ld_mreg", mem_mreg, 1'b1);
      chk("done_ld_dre",  mem_dre,  e_be);
      chk("done_ld_dreg", mem_dreg, e_ld);
      chk("done_ld_wreg", mem_wreg, ex_wreg);
    end else begin
      chk("done_st_mreg", mem_mreg, 1'b0);
      chk("done_st_dreg", mem_dreg, ex_dreg);
      chk("done_st_wreg", mem_wreg, ex_wreg);
    end
    next_cycle();
  endtask

  initial begin
    int sc;
    tbl[0] = '{NOP,     32'h0000_0100, 1'b0, 1'b1};
    tbl[1] = '{4'd9,    32'h0000_0101, 1'b0, 1'b1};
    tbl[2] = '{4'd15,   32'h0000_0003, 1'b0, 1'b1};
    tbl[3] = '{LH,      32'h0000_0101, 1'b1, 1'b0};
    tbl[4] = '{LHU,     32'h0000_0203, 1'b1, 1'b0};
    tbl[5] = '{SH,      32'h0000_0005, 1'b1, 1'b0};
    tbl[6] = '{LW,      32'h0000_0101, 1'b1, 1'b0};
    tbl[7] = '{LW,      32'h0000_0102, 1'b1, 1'b0};
    tbl[8] = '{SW,      32'h0000_0103, 1'b1, 1'b0};
    tbl[9] = '{SW,      32'h0000_0002, 1'b1, 1'b0};

    // Reset with a misaligned op on the inputs: nothing may be flagged or enabled.
    cpu_rst = 1'b1;
    set_op(LW, 32'h0000_0101, $urandom);
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    repeat (2) @(posedge cpu_clk_50M);
    #5;
    chk("rst_req",   dm_req,    1'b0);
    chk("rst_we",    dm_we,     1'b0);
    chk("rst_be",    dm_be,     4'b0000);
    chk("rst_addr",  dm_addr,   32'h0);
    chk("rst_wdata", dm_wdata,  32'h0);
    chk("rst_stall", stall_mem, 1'b0);
    chk("rst_ade",   mem_ade,   1'b0);
    chk("rst_berr",  mem_berr,  1'b0);
    chk("rst_mreg",  mem_mreg,  1'b0);
    chk("rst_wreg",  mem_wreg,  1'b0);
    chk("rst_whilo", mem_whilo, 1'b0);
    next_cycle();
    cpu_rst = 1'b0;

    // Table-driven single-cycle IDLE cases
    for (int i = 0; i < 10; i++) begin
      set_op(tbl[i].op, tbl[i].addr, $urandom);
      one_cycle($sformatf("tbl%0d", i), tbl[i].e_ade, tbl[i].e_wb);
    end

    // LB 0x103, ack in second WAIT cycle
    set_op(LB, 32'h0000_0103, $urandom);
    mem_op(1, 32'h1122_33F0, sc);
    chk("lb103_stall_cycles", sc, 3);

    // SH 0x202 store lane replication
    set_op(SH, 32'h0000_0202, 32'h0000_ABCD);
    mem_op(0, $urandom, sc);

    // LHU 0x300 with no ack: timeout after TO WAIT cycles, then IDLE
    set_op(LHU, 32'h0000_0300, $urandom);
    mem_op(-1, $urandom, sc);
    chk("timeout_stall_cycles", sc, TO + 1);
    set_op(NOP, 32'h0, $urandom);
    one_cycle("after_timeout", 1'b0, 1'b1);

    // Ack in the last counted WAIT cycle still completes normally
    set_op(LW, 32'h0000_0800, $urandom);
    mem_op(TO - 1, 32'hCAFE_F00D, sc);

    // Reset during WAIT aborts; later acks are ignored
    set_op(LW, 32'h0000_0500, $urandom);
    dm_ack = 1'b0;
    #4;
    chk("abort_issue_stall", stall_mem, 1'b1);
    next_cycle();
    #4;
    chk("abort_wait_req", dm_req, 1'b1);
    next_cycle();
    cpu_rst = 1'b1;
    ex_op   = NOP;
    #4;
    chk("abort_rst_stall", stall_mem, 1'b0);
    chk("abort_rst_wreg",  mem_wreg,  1'b0);
    chk("abort_rst_mreg",  mem_mreg,  1'b0);
    chk("abort_rst_berr",  mem_berr,  1'b0);
    next_cycle();
    cpu_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dm_ack   = 1'b1;
      dm_rdata = $urandom;
      #4;
      chk("abort_post_req",   dm_req,    1'b0);
      chk("abort_post_stall", stall_mem, 1'b0);
      chk("abort_post_mreg",  mem_mreg,  1'b0);
      chk("abort_post_berr",  mem_berr,  1'b0);
      next_cycle();
    end
    set_op(LW, 32'h0000_0504, $urandom);
    mem_op(0, 32'h8765_4321, sc);

    // Back-to-back LW, ALU op, SW with immediate acks
    set_op(LW, 32'h0000_0400, $urandom);
    mem_op(0, 32'h0BAD_BEEF, sc);
    chk("b2b_lw_cycles", sc + 1, 3);
    set_op(NOP, 32'h0000_0400, $urandom);
    one_cycle("b2b_alu", 1'b0, 1'b1);
    set_op(SW, 32'h0000_0404, $urandom);
    mem_op(0, $urandom, sc);
    chk("b2b_sw_cycles", sc + 1, 3);
    for (int i = 0; i < 2; i++) begin
      set_op(NOP, 32'h0000_0404, $urandom);
      one_cycle("b2b_noreissue", 1'b0, 1'b1);
    end

    // Randomized ops against the model
    for (int i = 0; i < 120; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          ack;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 8));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      set_op(op, a, $urandom);
      ex_wreg  = 1'($urandom_range(0, 1));
      ex_whilo = 1'($urandom_range(0, 1));
      if (m_size(op) == 0 || m_mis(op, a)) begin
        one_cycle("rnd_idle", m_size(op) != 0, m_size(op) == 0);
      end else begin
        ack = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
        mem_op(ack, $urandom, sc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
